mem_port2_arbiter: RTL and testbench

Shares the read/write port (port 2) of the dual-port byte-lane block-RAM memory between two requesters: the pipeline MEM stage (P, high priority) and the loader/debug master (D, low priority, starvation-protected). It also performs LC-3b lane steering: byte-store write-enable and data placement, and byte-load select with sign-extension. It drives the shared memory enable, so port-1 instruction fetch is never starved.

---
 rtl/mem_port2_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port2_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port2_arbiter.sv
// Port-2 arbiter for the byte-lane block RAM: pipeline MEM stage (P) vs loader/debug master (D).
// Performs LC-3b byte-store lane steering and byte-load sign extension.
module mem_port2_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        p_req,
    input  logic        p_we,
    input  logic        p_byte,
    input  logic [15:0] p_addr,
    input  logic [15:0] p_wdata,
    output logic        p_ack,
    output logic [15:0] p_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic [15:0] mem_addr2,
    output logic        mem_en,
    output logic        mem_we_low,
    output logic        mem_we_high,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data2_out,
    output logic        busy
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic               owner_q, owner_d;      // 1 = D owns the access
    logic [15:0]        addr_q, addr_d;
    logic               we_q, we_d;
    logic               byte_q, byte_d;
    logic               p_ack_q, p_ack_d, d_ack_q, d_ack_d;
    logic [15:0]        p_rdata_q, p_rdata_d, d_rdata_q, d_rdata_d;
    logic               we_low_q, we_low_d, we_high_q, we_high_d;
    logic [15:0]        mem_addr2_q, mem_addr2_d, mem_data_in_q, mem_data_in_d;
    logic               busy_q, busy_d;

    logic               grant_d_c;
    logic               sel_we, sel_byte;
    logic [15:0]        sel_addr, sel_wdata;
    logic [7:0]         rd_lane;
    logic [15:0]        rd_val;

    // Next-state, grant, lane steering and response formatting
    always_comb begin
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        we_d          = we_q;
        byte_d        = byte_q;
        p_ack_d       = 1'b0;
        d_ack_d       = 1'b0;
        p_rdata_d     = 16'h0000;
        d_rdata_d     = 16'h0000;
        we_low_d      = 1'b0;
        we_high_d     = 1'b0;
        mem_addr2_d   = mem_addr2_q;
        mem_data_in_d = mem_data_in_q;

        grant_d_c = d_req && (!p_req || (starve_cnt_q == CNT_W'(STARVE_LIMIT)));
        sel_we    = grant_d_c ? d_we    : p_we;
        sel_byte  = grant_d_c ? d_byte  : p_byte;
        sel_addr  = grant_d_c ? d_addr  : p_addr;
        sel_wdata = grant_d_c ? d_wdata : p_wdata;

        rd_lane = addr_q[0] ? mem_data2_out[15:8] : mem_data2_out[7:0];
        if (we_q) begin
            rd_val = 16'h0000;
        end else if (byte_q) begin
            rd_val = {{8{rd_lane[7]}}, rd_lane};
        end else begin
            rd_val = mem_data2_out;
        end

        case (state_q)
            IDLE: begin
                if (p_req || d_req) begin
                    state_d       = ISSUE;
                    owner_d       = grant_d_c;
                    addr_d        = sel_addr;
                    we_d          = sel_we;
                    byte_d        = sel_byte;
                    mem_addr2_d   = sel_addr;
                    mem_data_in_d = sel_byte ? {sel_wdata[7:0], sel_wdata[7:0]} : sel_wdata;
                    we_low_d      = sel_we && (!sel_byte || !sel_addr[0]);
                    we_high_d     = sel_we && (!sel_byte || sel_addr[0]);
                    if (grant_d_c || !d_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end
                end
            end
            ISSUE: state_d = RESP;
            RESP: begin
                state_d = IDLE;
                if (owner_q) begin
                    d_ack_d   = 1'b1;
                    d_rdata_d = rd_val;
                end else begin
                    p_ack_d   = 1'b1;
                    p_rdata_d = rd_val;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            starve_cnt_q  <= '0;
            owner_q       <= 1'b0;
            addr_q        <= 16'h0000;
            we_q          <= 1'b0;
            byte_q        <= 1'b0;
            p_ack_q       <= 1'b0;
            d_ack_q       <= 1'b0;
            p_rdata_q     <= 16'h0000;
            d_rdata_q     <= 16'h0000;
            we_low_q      <= 1'b0;
            we_high_q     <= 1'b0;
            mem_addr2_q   <= 16'h0000;
            mem_data_in_q <= 16'h0000;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            owner_q       <= owner_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            byte_q        <= byte_d;
            p_ack_q       <= p_ack_d;
            d_ack_q       <= d_ack_d;
            p_rdata_q     <= p_rdata_d;
            d_rdata_q     <= d_rdata_d;
            we_low_q      <= we_low_d;
            we_high_q     <= we_high_d;
            mem_addr2_q   <= mem_addr2_d;
            mem_data_in_q <= mem_data_in_d;
            busy_q        <= busy_d;
        end
    end

    // Port-1 fetch keeps the shared enable unless port 2 is issuing
    assign mem_en      = fetch_en || (state_q == ISSUE);
    assign p_ack       = p_ack_q;
    assign d_ack       = d_ack_q;
    assign p_rdata     = p_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign mem_we_low  = we_low_q;
    assign mem_we_high = we_high_q;
    assign mem_addr2   = mem_addr2_q;
    assign mem_data_in = mem_data_in_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mem_port2_arbiter.sv
// Directed bench for mem_port2_arbiter with a behavioural byte-lane RAM on port 2.
module tb_mem_port2_arbiter;
    logic        clk = 1'b0;
    logic        rst, fetch_en;
    logic        p_req, p_we, p_byte, d_req, d_we, d_byte;
    logic [15:0] p_addr, p_wdata, d_addr, d_wdata;
    logic        p_ack, d_ack, mem_en, mem_we_low, mem_we_high, busy;
    logic [15:0] p_rdata, d_rdata, mem_addr2, mem_data_in, mem_data2_out;

    int total = 0;
    int bad   = 0;

    logic        cap_we_lo, cap_we_hi, cap_en1, cap_en2;
    logic [15:0] cap_din;

    logic [15:0] ram [0:32767];

    always #5 clk = ~clk;

    mem_port2_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .p_req(p_req), .p_we(p_we), .p_byte(p_byte), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_ack(p_ack), .p_rdata(p_rdata),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr2(mem_addr2), .mem_en(mem_en), .mem_we_low(mem_we_low),
        .mem_we_high(mem_we_high), .mem_data_in(mem_data_in),
        .mem_data2_out(mem_data2_out), .busy(busy)
    );

    // Synchronous-read RAM: en=0 zeroes output, write returns pre-write word
    always @(posedge clk) begin
        if (mem_en) begin
            mem_data2_out <= ram[mem_addr2[15:1]];
            if (mem_we_low)  ram[mem_addr2[15:1]][7:0]  <= mem_data_in[7:0];
            if (mem_we_high) ram[mem_addr2[15:1]][15:8] <= mem_data_in[15:8];
        end else begin
            mem_data2_out <= 16'h0000;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One access on P (use_d=0) or D, driven and sampled on negedges
    task automatic access(input logic use_d, input logic we, input logic byt,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input string tag, input logic [15:0] exp_rdata);
        logic got_ack = 1'b0;
        logic other   = 1'b0;
        int   lat     = 0;
        logic [15:0] rd = 16'h0000;
        if (use_d) begin
            d_we = we; d_byte = byt; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            p_we = we; p_byte = byt; p_addr = addr; p_wdata = wdata; p_req = 1'b1;
        end
        for (int n = 1; n <= 8 && !got_ack; n++) begin
            @(negedge clk);
            if (n == 1) begin
                cap_we_lo = mem_we_low; cap_we_hi = mem_we_high;
                cap_din = mem_data_in; cap_en1 = mem_en;
            end
            if (n == 2) cap_en2 = mem_en;
            if (use_d ? p_ack : d_ack) other = 1'b1;
            if (use_d ? d_ack : p_ack) begin
                got_ack = 1'b1;
                lat = n;
                rd = use_d ? d_rdata : p_rdata;
            end
        end
        p_req = 1'b0;
        d_req = 1'b0;
        check({tag, "_ack"}, 32'(got_ack), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check({tag, "_rdata"}, 32'(rd), 32'(exp_rdata));
        check({tag, "_other_ack"}, 32'(other), 32'd0);
    endtask

    initial begin
        logic order [10];
        logic exp_order [10];
        int   k, both, noack;

        rst = 1'b1; fetch_en = 1'b1;
        p_req = 0; p_we = 0; p_byte = 0; p_addr = 0; p_wdata = 0;
        d_req = 0; d_we = 0; d_byte = 0; d_addr = 0; d_wdata = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_acks", 32'({p_ack, d_ack}), 0);
        check("rst_rdata", {p_rdata, d_rdata}, 0);
        check("rst_we", 32'({mem_we_low, mem_we_high}), 0);
        check("rst_addr_din", {mem_addr2, mem_data_in}, 0);
        check("rst_cnt", 32'(dut.starve_cnt_q), 0);
        rst = 1'b0;
        @(negedge clk);

        // Word store / load
        access(0, 1, 0, 16'h3000, 16'hBEEF, "wst", 16'h0000);
        check("wst_we", 32'({cap_we_lo, cap_we_hi}), 32'b11);
        check("wst_din", 32'(cap_din), 32'hBEEF);
        access(0, 0, 0, 16'h3000, 16'h0000, "wld", 16'hBEEF);

        // Byte lanes
        access(0, 1, 0, 16'h3000, 16'h1234, "pre", 16'h0000);
        access(0, 1, 1, 16'h3001, 16'h00F0, "bst", 16'h0000);
        check("bst_we", 32'({cap_we_lo, cap_we_hi}), 32'b01);
        check("bst_din", 32'(cap_din), 32'hF0F0);
        access(0, 0, 0, 16'h3000, 16'h0000, "bwld", 16'hF034);
        access(0, 0, 1, 16'h3001, 16'h0000, "bhi", 16'hFFF0);
        access(0, 0, 1, 16'h3000, 16'h0000, "blo", 16'h0034);
        check("bld_we", 32'({cap_we_lo, cap_we_hi}), 0);

        // Starvation: both held, expect P,P,P,P,D repeating
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        p_we = 0; p_byte = 0; p_addr = 16'h3000;
        d_we = 0; d_byte = 0; d_addr = 16'h3000;
        p_req = 1; d_req = 1;
        k = 0; both = 0;
        for (int n = 0; n < 60 && k < 10; n++) begin
            @(negedge clk);
            if (p_ack && d_ack) both++;
            if (p_ack && k < 10) begin order[k] = 1'b0; k++; end
            if (d_ack && k < 10) begin
                order[k] = 1'b1; k++;
                check("starve_drdata", 32'(d_rdata), 32'hF034);
            end
        end
        p_req = 0; d_req = 0;
        check("starve_count", 32'(k), 10);
        check("starve_both", 32'(both), 0);
        for (int i = 0; i < 10; i++)
            if (i < k) check($sformatf("starve_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
        @(negedge clk);

        // mem_en ownership
        fetch_en = 1'b0;
        @(negedge clk);
        check("en_idle", 32'(mem_en), 0);
        access(1, 0, 0, 16'h3000, 16'h0000, "den", 16'hF034);
        check("en_issue", 32'(cap_en1), 1);
        check("en_resp", 32'(cap_en2), 0);
        check("en_after", 32'(mem_en), 0);
        fetch_en = 1'b1;

        // Reset during RESP of a P load (D waiting bumps the counter)
        p_we = 0; p_byte = 0; p_addr = 16'h3000; p_req = 1;
        d_we = 0; d_byte = 0; d_addr = 16'h3000; d_req = 1;
        @(negedge clk);
        check("rr_cnt_pre", 32'(dut.starve_cnt_q), 1);
        @(negedge clk);
        rst = 1; p_req = 0; d_req = 0;
        @(negedge clk);
        check("rr_acks", 32'({p_ack, d_ack}), 0);
        check("rr_busy", 32'(busy), 0);
        check("rr_cnt", 32'(dut.starve_cnt_q), 0);
        check("rr_we", 32'({mem_we_low, mem_we_high}), 0);
        rst = 0;
        @(negedge clk);
        check("rr_acks2", 32'({p_ack, d_ack}), 0);
        access(0, 0, 0, 16'h3000, 16'h0000, "rr_after", 16'hF034);

        // Reset during ISSUE of a byte store: write still commits
        p_we = 1; p_byte = 1; p_addr = 16'h3000; p_wdata = 16'h00AA; p_req = 1;
        @(negedge clk);
        check("ri_we", 32'({mem_we_low, mem_we_high}), 32'b10);
        check("ri_din", 32'(mem_data_in), 32'hAAAA);
        rst = 1; p_req = 0;
        noack = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            rst = 0;
            if (p_ack || d_ack) noack++;
        end
        check("ri_noack", 32'(noack), 0);
        access(0, 0, 0, 16'h3000, 16'h0000, "ri_read", 16'hF0AA);
        access(0, 0, 1, 16'h3000, 16'h0000, "ri_lowbyte", 16'hFFAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
